// File: rtl/wash_mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// wash_mode_ctrl_if
// Front-panel / wash-timer bundle for wash_mode_ctrl.
//   power_led      panel -> ctrl   1 = machine powered (level)
//   start_pause    panel -> ctrl   start/pause button, async level
//   module_select  panel -> ctrl   programme-select button, async level
//   if_finish      timer -> ctrl   1-cycle pulse, programme complete
//   model_now      ctrl -> timers  current programme index
//   running        ctrl -> timers  1 while in RUN
//   paused         ctrl -> timers  1 while in PAUSE
//   mode_done      ctrl -> timers  1-cycle pulse when a finish is accepted
//   state_dbg      ctrl -> debug   raw FSM state (OFF=0 IDLE=1 RUN=2 PAUSE=3)
// master = panel/timer side, slave = controller side.
// ---------------------------------------------------------------------------
interface wash_mode_ctrl_if #(
    parameter int MODE_W = 3
);
    logic              power_led;
    logic              start_pause;
    logic              module_select;
    logic              if_finish;
    logic [MODE_W-1:0] model_now;
    logic              running;
    logic              paused;
    logic              mode_done;
    logic [1:0]        state_dbg;

    modport master (
        output power_led, start_pause, module_select, if_finish,
        input  model_now, running, paused, mode_done, state_dbg
    );

    modport slave (
        input  power_led, start_pause, module_select, if_finish,
        output model_now, running, paused, mode_done, state_dbg
    );
endinterface

// File: rtl/wash_mode_ctrl.sv
// ---------------------------------------------------------------------------
// wash_mode_ctrl
// Washing-machine programme selector and OFF/IDLE/RUN/PAUSE controller.
// Select presses step the programme index in IDLE; the index is locked while
// a wash runs and returns to DEFAULT_MODE on finish or power-off.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of wash_mode_ctrl_if (see that file for signals)
//
// Optional feature: define WASH_DEBOUNCE_EN to insert a DEB_CYCLES-sample
// debouncer between each button synchroniser and its edge detector.
//
// Signal contracts (there is no valid/ready pair on this block):
//   buttons and power_led are levels; a press is a rising edge of the
//   filtered button. if_finish is a single-cycle pulse that is only consumed
//   in RUN/PAUSE. mode_done is a single-cycle pulse, registered, appearing in
//   the same cycle the state shows IDLE after an accepted finish.
// ---------------------------------------------------------------------------
module wash_mode_ctrl #(
    parameter int NUM_MODES    = 6,
    parameter int MODE_W       = 3,
    parameter int DEFAULT_MODE = 0,
    parameter int DEB_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    wash_mode_ctrl_if.slave       bus
);

    // Elaboration-time sanity check of the parameter set.
    if (NUM_MODES < 2 || NUM_MODES > (2 ** MODE_W) ||
        DEFAULT_MODE < 0 || DEFAULT_MODE >= NUM_MODES || DEB_CYCLES < 1) begin : g_param_check
        $error("wash_mode_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_IDLE  = 2'd1,
        S_RUN   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    localparam logic [MODE_W-1:0] DEF_M  = MODE_W'(DEFAULT_MODE);
    localparam logic [MODE_W-1:0] LAST_M = MODE_W'(NUM_MODES - 1);

    // Bit 0 = start_pause, bit 1 = module_select.
    logic [1:0] sync1, sync2, filt, filt_d;
    logic       start_press, sel_press;

    state_t            state, state_n;
    logic [MODE_W-1:0] model, model_n;
    logic              done_q, done_n;

    // Synchroniser and edge-detect history load 1 in reset so a button held
    // across reset release is not seen as a press until it is re-pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt_d <= 2'b11;
        end else begin
            sync1  <= {bus.module_select, bus.start_pause};
            sync2  <= sync1;
            filt_d <= filt;
        end
    end

`ifdef WASH_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [CNT_W-1:0] cnt [2];

    // filt follows sync2 only after DEB_CYCLES consecutive mismatching edges;
    // any edge where they agree restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 2'b11;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign filt = sync2;
`endif

    assign start_press = filt[0] & ~filt_d[0];
    assign sel_press   = filt[1] & ~filt_d[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_OFF;
            model  <= DEF_M;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            model  <= model_n;
            done_q <= done_n;
        end
    end

    // Priority: power loss > finish > start press > select press.
    always_comb begin
        state_n = state;
        model_n = model;
        done_n  = 1'b0;
        if (!bus.power_led) begin
            state_n = S_OFF;
            model_n = DEF_M;
        end else begin
            case (state)
                S_OFF: begin
                    state_n = S_IDLE;
                end
                S_IDLE: begin
                    if (start_press) begin
                        state_n = S_RUN;
                    end else if (sel_press) begin
                        // Wrap at NUM_MODES-1 so a non-power-of-2 count never
                        // reaches an unused index.
                        model_n = (model == LAST_M) ? '0 : model + MODE_W'(1);
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (bus.if_finish) begin
                        state_n = S_IDLE;
                        model_n = DEF_M;
                        done_n  = 1'b1;
                    end else if (start_press) begin
                        state_n = (state == S_RUN) ? S_PAUSE : S_RUN;
                    end
                end
                default: begin
                    state_n = S_OFF;
                    model_n = DEF_M;
                end
            endcase
        end
    end

    assign bus.model_now = model;
    assign bus.running   = (state == S_RUN);
    assign bus.paused    = (state == S_PAUSE);
    assign bus.mode_done = done_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_wash_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wash_mode_ctrl
// Directed test of wash_mode_ctrl (NUM_MODES=6, MODE_W=3, DEFAULT_MODE=0).
// The driver updates a small reference model and queues every output change
// it expects, with the clock edge it should appear on. The monitor watches
// the output tuple at each falling edge and pops/compares on every change.
// Also builds with WASH_DEBOUNCE_EN (press latency 7, glitch rejection).
// ---------------------------------------------------------------------------
module tb_wash_mode_ctrl;

    localparam int NUM_MODES = 6;
    localparam int MODE_W    = 3;
`ifdef WASH_DEBOUNCE_EN
    localparam int LAT  = 7;
    localparam int HOLD = 10;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 5;
`endif
    localparam int GAP = LAT + 2;
    localparam int W   = 8;

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    int   cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wash_mode_ctrl_if #(.MODE_W(MODE_W)) bus ();

    wash_mode_ctrl #(
        .NUM_MODES   (NUM_MODES),
        .MODE_W      (MODE_W),
        .DEFAULT_MODE(0),
        .DEB_CYCLES  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           cyc_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    logic [1:0]        m_state;
    logic [MODE_W-1:0] m_model;
    logic              m_done;
    logic [W-1:0]      last_tup = 'x;

    task automatic expect_at(input string name, input int at_cyc);
        logic [W-1:0] t;
        t = {m_state, m_model, (m_state == S_RUN), (m_state == S_PAUSE), m_done};
        if (t !== last_tup) begin
            exp_q.push_back(t);
            cyc_q.push_back(at_cyc);
            name_q.push_back(name);
            last_tup = t;
        end
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] prev = 'x;

    always @(negedge clk) begin
        logic [W-1:0] cur;
        logic [W-1:0] e;
        int           ec;
        string        nm;
        cur = {bus.state_dbg, bus.model_now, bus.running, bus.paused, bus.mode_done};
        if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got %b at cycle %0d, required no change", cur, cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                nm = name_q.pop_front();
                if (cur !== e || cyc != ec) begin
                    errors++;
                    $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                             nm, cur, cyc, e, ec);
                end
            end
        end
        prev = cur;
    end

    // ---------------- driver tasks ----------------
    task automatic sel_press();
        int t0;
        t0 = cyc;
        bus.module_select = 1'b1;
        if (m_state == S_IDLE) begin
            m_model = (m_model == MODE_W'(NUM_MODES - 1)) ? '0 : m_model + 1'b1;
            expect_at("select_step", t0 + LAT);
        end
        repeat (HOLD) @(negedge clk);
        bus.module_select = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic start_press();
        int t0;
        t0 = cyc;
        bus.start_pause = 1'b1;
        case (m_state)
            S_IDLE:  m_state = S_RUN;
            S_RUN:   m_state = S_PAUSE;
            S_PAUSE: m_state = S_RUN;
            default: m_state = m_state;
        endcase
        expect_at("start_pause", t0 + LAT);
        repeat (HOLD) @(negedge clk);
        bus.start_pause = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic finish_pulse();
        int t0;
        t0 = cyc;
        bus.if_finish = 1'b1;
        if (m_state == S_RUN || m_state == S_PAUSE) begin
            m_state = S_IDLE;
            m_model = '0;
            m_done  = 1'b1;
            expect_at("finish_done_rise", t0 + 1);
            m_done  = 1'b0;
            expect_at("finish_done_fall", t0 + 2);
        end
        @(negedge clk);
        bus.if_finish = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        reset             = 1'b1;
        bus.power_led     = 1'b0;
        bus.start_pause   = 1'b0;
        bus.module_select = 1'b0;
        bus.if_finish     = 1'b0;
        m_state = S_OFF;
        m_model = '0;
        m_done  = 1'b0;
        expect_at("reset_state", 1);
        repeat (2) @(negedge clk);

        // Power-up: OFF -> IDLE one edge after power_led rises.
        reset         = 1'b0;
        bus.power_led = 1'b1;
        m_state = S_IDLE;
        expect_at("power_on_idle", cyc + 1);
        repeat (2) @(negedge clk);

        // Seven select presses: 1,2,3,4,5,0,1.
        for (int i = 0; i < 7; i++) sel_press();

        // To programme 3, run, selects locked, pause, resume.
        sel_press();
        sel_press();
        start_press();
        sel_press();
        sel_press();
        start_press();
        start_press();

        // Finish and start press land on the same edge: finish wins.
        t0 = cyc;
        bus.start_pause = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        bus.if_finish = 1'b1;
        m_state = S_IDLE;
        m_model = '0;
        m_done  = 1'b1;
        expect_at("finish_over_start", t0 + LAT);
        m_done  = 1'b0;
        expect_at("finish_done_fall", t0 + LAT + 1);
        @(negedge clk);
        bus.if_finish = 1'b0;
        repeat (HOLD - LAT) @(negedge clk);
        bus.start_pause = 1'b0;
        repeat (GAP) @(negedge clk);

        // Finish in IDLE is ignored.
        finish_pulse();

        // Programme 2, run, lose power: OFF, default mode, no mode_done.
        sel_press();
        sel_press();
        start_press();
        bus.power_led = 1'b0;
        m_state = S_OFF;
        m_model = '0;
        expect_at("power_loss_off", cyc + 1);
        repeat (3) @(negedge clk);
        sel_press();
        bus.power_led = 1'b1;
        m_state = S_IDLE;
        expect_at("power_on_idle", cyc + 1);
        repeat (3) @(negedge clk);

        // Start and select in the same IDLE cycle: run with unchanged mode.
        sel_press();
        t0 = cyc;
        bus.start_pause   = 1'b1;
        bus.module_select = 1'b1;
        m_state = S_RUN;
        expect_at("start_beats_select", t0 + LAT);
        repeat (HOLD) @(negedge clk);
        bus.start_pause   = 1'b0;
        bus.module_select = 1'b0;
        repeat (GAP) @(negedge clk);
        start_press();
        finish_pulse();

        // Select held through reset release gives no press until re-pressed.
        sel_press();
        reset             = 1'b1;
        bus.module_select = 1'b1;
        m_state = S_OFF;
        m_model = '0;
        expect_at("reset_mid_idle", cyc + 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_state = S_IDLE;
        expect_at("reset_release_idle", cyc + 1);
        repeat (HOLD + GAP) @(negedge clk);
        bus.module_select = 1'b0;
        repeat (GAP) @(negedge clk);
        sel_press();

`ifdef WASH_DEBOUNCE_EN
        // A 3-cycle glitch is shorter than the debounce window.
        bus.module_select = 1'b1;
        repeat (3) @(negedge clk);
        bus.module_select = 1'b0;
        repeat (GAP + 4) @(negedge clk);
        sel_press();
`endif

        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #400000;
        $display("FAIL timeout: got no completion by %0t, required completion", $time);
        $fatal(1);
    end

endmodule
